// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state type, frame-counter width and counter-width helper for the TDM receiver
package tdm_pkg;
    typedef enum logic [1:0] {IDLE, ALIGN, ACTIVE, WAIT} tdm_rx_state_t;
    localparam int TDM_FRAME_CNT_W = 16;
    function automatic int tdm_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tdm_sync_edge.sv
// tdm_sync_edge: 2-flop synchroniser with rising-edge detect on the synchronised level
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   d     - asynchronous input
//   rise  - high for one cycle when the synchronised level goes 0 -> 1
module tdm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [2:0] sr;
    always_ff @(posedge clk) begin
        sr <= !rst_n ? 3'b000 : {sr[1:0], d};
    end
    assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/tdm_rx_frame.sv
// tdm_rx_frame: oversampled TDM microphone-array receiver delivering one frame-aligned sample set per frame
//   clk_in          - system clock, at least 4x sck
//   rst_n_in        - synchronous active-low reset
//   sck_in, ws_in, sd_in - asynchronous TDM serial clock, frame sync and data
//   audio_out       - last complete frame, slot-indexed signed samples
//   audio_valid_out - one-cycle pulse when audio_out updates
//   frame_err_out   - one-cycle pulse on a short frame (only when TDM_RX_ERR_EN is defined)
//   frame_count_out - completed frames, wrapping
module tdm_rx_frame
    import tdm_pkg::*;
#(
    parameter int BIT_WIDTH  = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int SLOTS      = 8,
    parameter int WS_DELAY   = 1
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              sck_in,
    input  logic                              ws_in,
    input  logic                              sd_in,
    output logic signed [BIT_WIDTH-1:0]       audio_out [SLOTS],
    output logic                              audio_valid_out,
    output logic                              frame_err_out,
    output logic [TDM_FRAME_CNT_W-1:0]        frame_count_out
);
`ifdef TDM_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int BC_W = tdm_cnt_w(SLOT_WIDTH);
    localparam int SC_W = tdm_cnt_w(SLOTS);
    localparam int AC_W = tdm_cnt_w(WS_DELAY);
    localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(BIT_WIDTH - 1);
    localparam logic [BC_W-1:0] SLOT_END   = BC_W'(SLOT_WIDTH - 1);
    localparam logic [SC_W-1:0] SLOT_LAST  = SC_W'(SLOTS - 1);
    localparam logic [AC_W-1:0] ALIGN_LAST = AC_W'((WS_DELAY > 0) ? WS_DELAY - 1 : 0);
    localparam tdm_rx_state_t START_STATE = (WS_DELAY == 0) ? ACTIVE : ALIGN;

    tdm_rx_state_t        state;
    logic                 sck_rise;
    logic [1:0]           ws_sync;
    logic [1:0]           sd_sync;
    logic                 ws_prev;
    logic [AC_W-1:0]      align_cnt;
    logic [BC_W-1:0]      bit_cnt;
    logic [SC_W-1:0]      slot_cnt;
    logic [BIT_WIDTH-1:0] shift;
    logic [BIT_WIDTH-1:0] staging [SLOTS];
    logic                 frame_start;
    logic                 short_frame;
    logic                 cap;
    logic                 last_bit;
    logic                 frame_done;
    logic [BC_W-1:0]      cap_bit;
    logic [SC_W-1:0]      cap_slot;
    logic [BIT_WIDTH-1:0] shift_nxt;

    tdm_sync_edge u_sck (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .d     (sck_in),
        .rise  (sck_rise)
    );

    // A frame start always restarts capture; the edge that carries a bit is either the
    // frame-start edge itself (zero delay), the last alignment edge, or any active edge.
    // Bit/slot positions are forced to zero for the first captured bit of a frame.
    always_comb begin
        frame_start = sck_rise && ws_sync[1] && !ws_prev;
        short_frame = frame_start && (state == ALIGN || state == ACTIVE);
        cap = sck_rise && (frame_start ? (WS_DELAY == 0)
                                       : (state == ACTIVE || (state == ALIGN && align_cnt == ALIGN_LAST)));
        cap_bit = (state == ACTIVE && !frame_start) ? bit_cnt : '0;
        cap_slot = (state == ACTIVE && !frame_start) ? slot_cnt : '0;
        shift_nxt = BIT_WIDTH'({shift, sd_sync[1]});
        last_bit = cap_bit == BIT_LAST;
        frame_done = cap && last_bit && cap_slot == SLOT_LAST;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            ws_sync         <= '0;
            sd_sync         <= '0;
            ws_prev         <= 1'b0;
            state           <= IDLE;
            align_cnt       <= '0;
            bit_cnt         <= '0;
            slot_cnt        <= '0;
            shift           <= '0;
            staging         <= '{default: '0};
            audio_out       <= '{default: '0};
            audio_valid_out <= 1'b0;
            frame_err_out   <= 1'b0;
            frame_count_out <= '0;
        end else begin
            ws_sync         <= {ws_sync[0], ws_in};
            sd_sync         <= {sd_sync[0], sd_in};
            audio_valid_out <= 1'b0;
            frame_err_out   <= ERR_EN && short_frame;
            if (sck_rise) ws_prev <= ws_sync[1];
            // a short frame's partial slots must never leak into a later frame
            if (short_frame) staging <= '{default: '0};
            if (frame_start) begin
                state     <= START_STATE;
                align_cnt <= '0;
            end else if (sck_rise && state == ALIGN) begin
                if (align_cnt == ALIGN_LAST) state <= ACTIVE;
                else align_cnt <= align_cnt + AC_W'(1);
            end
            if (cap) begin
                if (cap_bit <= BIT_LAST) shift <= shift_nxt;
                if (last_bit) staging[cap_slot] <= shift_nxt;
                // the final slot goes straight from the shifter so the frame publishes on its LSB edge
                if (frame_done) begin
                    for (int i = 0; i < SLOTS - 1; i++) audio_out[i] <= staging[i];
                    audio_out[SLOTS-1] <= shift_nxt;
                    audio_valid_out    <= 1'b1;
                    frame_count_out    <= frame_count_out + TDM_FRAME_CNT_W'(1);
                    state              <= WAIT;
                end
                bit_cnt  <= (cap_bit == SLOT_END) ? '0 : cap_bit + BC_W'(1);
                slot_cnt <= (cap_bit == SLOT_END) ? cap_slot + SC_W'(1) : cap_slot;
            end
        end
    end
endmodule
